// File: rtl/mul_issue_sched.sv
// mul_issue_sched: age-ordered, collapsing reservation queue for the multiply
// unit. Ops enter at the tail, wake up from the CDB, and the oldest ready op is
// offered to the multiplier under valid/ready.
// Optional build macro: MUL_SCHED_WAKEUP_BYPASS_EN lets select see the current
// CDB broadcast, so a woken op can issue in the same cycle.
module mul_issue_sched #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TAG_W-1:0]           in_ra_tag,
    input  logic [TAG_W-1:0]           in_rb_tag,
    input  logic                       in_ra_rdy,
    input  logic                       in_rb_rdy,
    input  logic [TAG_W-1:0]           in_rw_tag,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [TAG_W-1:0]           iss_ra_tag,
    output logic [TAG_W-1:0]           iss_rb_tag,
    output logic [TAG_W-1:0]           iss_rw_tag,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] ra_tag;
        logic             ra_rdy;
        logic [TAG_W-1:0] rb_tag;
        logic             rb_rdy;
        logic [TAG_W-1:0] rw_tag;
    } entry_t;

    entry_t           q     [DEPTH];
    entry_t           woken [DEPTH];
    entry_t           nxt   [DEPTH];
    entry_t           new_e;
    logic [DEPTH-1:0] ra_hit, rb_hit, ra_ok, rb_ok;
    logic             found, fire, push;
    logic [CW-1:0]    sel, tail;

    // CDB tag match per entry and the readiness view used by select
    always_comb begin
        ra_hit = '0;
        rb_hit = '0;
        ra_ok  = '0;
        rb_ok  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ra_hit[i] = cdb_valid && (cdb_tag == q[i].ra_tag);
            rb_hit[i] = cdb_valid && (cdb_tag == q[i].rb_tag);
`ifdef MUL_SCHED_WAKEUP_BYPASS_EN
            ra_ok[i]  = q[i].ra_rdy | ra_hit[i];
            rb_ok[i]  = q[i].rb_rdy | rb_hit[i];
`else
            ra_ok[i]  = q[i].ra_rdy;
            rb_ok[i]  = q[i].rb_rdy;
`endif
        end
    end

    // Oldest-first select: scan downward so the lowest ready index wins
    always_comb begin
        found      = 1'b0;
        sel        = '0;
        iss_ra_tag = '0;
        iss_rb_tag = '0;
        iss_rw_tag = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (q[i].valid && ra_ok[i] && rb_ok[i]) begin
                found      = 1'b1;
                sel        = CW'(i);
                iss_ra_tag = q[i].ra_tag;
                iss_rb_tag = q[i].rb_tag;
                iss_rw_tag = q[i].rw_tag;
            end
        end
    end

    // A full queue refuses dispatch even when an issue frees a slot this cycle
    assign in_ready  = !rst && !flush && (count < CW'(DEPTH));
    assign iss_valid = found && !rst && !flush;
    assign fire      = iss_valid && iss_ready;
    assign push      = in_valid && in_ready;
    assign tail      = count - CW'(fire);

    // Next queue image: wakeup, then compaction past the issued slot, then tail write
    always_comb begin
        new_e.valid  = 1'b1;
        new_e.ra_tag = in_ra_tag;
        new_e.rb_tag = in_rb_tag;
        new_e.rw_tag = in_rw_tag;
        new_e.ra_rdy = in_ra_rdy || (cdb_valid && cdb_tag == in_ra_tag);
        new_e.rb_rdy = in_rb_rdy || (cdb_valid && cdb_tag == in_rb_tag);
        for (int i = 0; i < DEPTH; i++) begin
            woken[i]        = q[i];
            woken[i].ra_rdy = q[i].ra_rdy | ra_hit[i];
            woken[i].rb_rdy = q[i].rb_rdy | rb_hit[i];
            nxt[i]          = woken[i];
        end
        if (fire) begin
            for (int i = 0; i < DEPTH-1; i++)
                if (CW'(i) >= sel) nxt[i] = woken[i+1];
            nxt[DEPTH-1] = '0;
        end
        for (int i = 0; i < DEPTH; i++)
            if (push && CW'(i) == tail) nxt[i] = new_e;
    end

    // Queue and occupancy registers; reset and flush both clear everything
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q[i] <= nxt[i];
            count <= count + CW'(push) - CW'(fire);
        end
    end
endmodule

// File: tb/tb_mul_issue_sched.sv
// Bench for mul_issue_sched: directed ops, expected issue order kept in a
// scoreboard queue and popped by a monitor on every issue handshake.
module tb_mul_issue_sched;
    logic       clk = 1'b0;
    logic       rst, flush, in_valid, in_ready;
    logic [3:0] in_ra_tag, in_rb_tag, in_rw_tag, cdb_tag;
    logic       in_ra_rdy, in_rb_rdy, cdb_valid;
    logic       iss_valid, iss_ready;
    logic [3:0] iss_ra_tag, iss_rb_tag, iss_rw_tag;
    logic [2:0] count;

    int errors = 0;
    int checks = 0;
    logic [11:0] exp_q [$];

    mul_issue_sched #(.DEPTH(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ra_tag(in_ra_tag), .in_rb_tag(in_rb_tag),
        .in_ra_rdy(in_ra_rdy), .in_rb_rdy(in_rb_rdy), .in_rw_tag(in_rw_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_ra_tag(iss_ra_tag), .iss_rb_tag(iss_rb_tag), .iss_rw_tag(iss_rw_tag),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic disp(input logic [3:0] ra, input logic ra_r,
                        input logic [3:0] rb, input logic rb_r, input logic [3:0] rw);
        in_valid = 1'b1;
        in_ra_tag = ra; in_ra_rdy = ra_r;
        in_rb_tag = rb; in_rb_rdy = rb_r;
        in_rw_tag = rw;
    endtask

    // Monitor: every accepted issue must match the oldest expected op
    always @(negedge clk) begin
        if (iss_valid && iss_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL issue_unexpected: got rw=%0d expected no issue", iss_rw_tag);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                chk("issue_tags", {iss_ra_tag, iss_rb_tag, iss_rw_tag}, e);
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_ra_tag = '0; in_rb_tag = '0; in_rw_tag = '0;
        in_ra_rdy = 1'b0; in_rb_rdy = 1'b0;
        cdb_valid = 1'b0; cdb_tag = '0; iss_ready = 1'b0;

        // Reset
        step(); step();
        at_neg();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_iss_valid", iss_valid, 0);
        step(); rst = 1'b0;
        at_neg();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_count", count, 0);
        chk("post_rst_iss_valid", iss_valid, 0);

        // Single op, both ready: offered the cycle after dispatch
        step();
        iss_ready = 1'b1;
        disp(4'd1, 1, 4'd2, 1, 4'd5);
        exp_q.push_back({4'd1, 4'd2, 4'd5});
        step(); in_valid = 1'b0;
        at_neg();
        chk("single_iss_valid", iss_valid, 1);
        chk("single_rw", iss_rw_tag, 5);
        chk("single_count", count, 1);
        step();
        at_neg();
        chk("single_drain_count", count, 0);

        // Wakeup latency
        step();
        disp(4'd3, 0, 4'd4, 1, 4'd6);
        exp_q.push_back({4'd3, 4'd4, 4'd6});
        step(); in_valid = 1'b0;
        at_neg();
        chk("wake_wait_iss_valid", iss_valid, 0);
        step(); cdb_valid = 1'b1; cdb_tag = 4'd3;
        at_neg();
`ifdef MUL_SCHED_WAKEUP_BYPASS_EN
        chk("wake_cycle_iss_valid", iss_valid, 1);
`else
        chk("wake_cycle_iss_valid", iss_valid, 0);
`endif
        step(); cdb_valid = 1'b0;
        at_neg();
`ifdef MUL_SCHED_WAKEUP_BYPASS_EN
        chk("wake_after_count", count, 0);
`else
        chk("wake_next_iss_valid", iss_valid, 1);
`endif
        step();
        at_neg();
        chk("wake_drain_count", count, 0);

        // Dispatch bypass: CDB matches a source in the dispatch cycle
        step();
        disp(4'd8, 0, 4'd9, 1, 4'd7);
        cdb_valid = 1'b1; cdb_tag = 4'd8;
        exp_q.push_back({4'd8, 4'd9, 4'd7});
        step(); in_valid = 1'b0; cdb_valid = 1'b0;
        at_neg();
        chk("disp_bypass_iss_valid", iss_valid, 1);
        step();
        at_neg();
        chk("disp_bypass_count", count, 0);

        // Age order: A waits on tag 7, B and C issue first
        step(); iss_ready = 1'b0;
        disp(4'd7, 0, 4'd1, 1, 4'd1);
        step(); disp(4'd2, 1, 4'd3, 1, 4'd2);
        step(); disp(4'd4, 1, 4'd5, 1, 4'd3);
        step(); in_valid = 1'b0;
        exp_q.push_back({4'd2, 4'd3, 4'd2});
        exp_q.push_back({4'd4, 4'd5, 4'd3});
        exp_q.push_back({4'd7, 4'd1, 4'd1});
        at_neg();
        chk("age_count", count, 3);
        chk("age_first_rw", iss_rw_tag, 2);
        step(); iss_ready = 1'b1;
        step(); step();
        at_neg();
        chk("age_a_blocked", iss_valid, 0);
        chk("age_a_count", count, 1);
        step(); cdb_valid = 1'b1; cdb_tag = 4'd7;
        step(); cdb_valid = 1'b0;
        step();
        at_neg();
        chk("age_drain_count", count, 0);

        // Full and backpressure
        step(); iss_ready = 1'b0;
        disp(4'd1, 1, 4'd1, 1, 4'd8);
        step(); disp(4'd2, 1, 4'd2, 1, 4'd9);
        step(); disp(4'd3, 1, 4'd3, 1, 4'd10);
        step(); disp(4'd4, 1, 4'd4, 1, 4'd11);
        step(); in_valid = 1'b0;
        exp_q.push_back({4'd1, 4'd1, 4'd8});
        exp_q.push_back({4'd2, 4'd2, 4'd9});
        exp_q.push_back({4'd3, 4'd3, 4'd10});
        exp_q.push_back({4'd4, 4'd4, 4'd11});
        exp_q.push_back({4'd5, 4'd5, 4'd12});
        at_neg();
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        chk("full_rw", iss_rw_tag, 8);
        step();
        at_neg();
        chk("full_rw_stable", iss_rw_tag, 8);
        step(); iss_ready = 1'b1;
        disp(4'd5, 1, 4'd5, 1, 4'd12);
        at_neg();
        chk("full_no_reuse", in_ready, 0);
        step(); iss_ready = 1'b0;
        at_neg();
        chk("full_after_issue_count", count, 3);
        chk("full_after_in_ready", in_ready, 1);
        step(); in_valid = 1'b0;
        at_neg();
        chk("full_refill_count", count, 4);
        step(); iss_ready = 1'b1;
        step(); step(); step(); step();
        at_neg();
        chk("full_drain_count", count, 0);

        // Simultaneous dispatch and issue at count=2
        step(); iss_ready = 1'b0;
        disp(4'd9, 0, 4'd1, 1, 4'd1);
        step(); disp(4'd2, 1, 4'd2, 1, 4'd2);
        step(); disp(4'd3, 1, 4'd3, 1, 4'd3);
        iss_ready = 1'b1;
        exp_q.push_back({4'd2, 4'd2, 4'd2});
        exp_q.push_back({4'd3, 4'd3, 4'd3});
        exp_q.push_back({4'd9, 4'd1, 4'd1});
        at_neg();
        chk("sim_pre_count", count, 2);
        step(); in_valid = 1'b0; iss_ready = 1'b0;
        at_neg();
        chk("sim_count", count, 2);
        chk("sim_new_rw", iss_rw_tag, 3);
        step(); iss_ready = 1'b1;
        step(); cdb_valid = 1'b1; cdb_tag = 4'd9;
        step(); cdb_valid = 1'b0;
        step();
        at_neg();
        chk("sim_drain_count", count, 0);

        // Flush with 3 entries while dispatching and ready to issue
        step(); iss_ready = 1'b0;
        disp(4'd1, 1, 4'd1, 1, 4'd4);
        step(); disp(4'd1, 1, 4'd1, 1, 4'd5);
        step(); disp(4'd1, 1, 4'd1, 1, 4'd6);
        step(); disp(4'd1, 1, 4'd1, 1, 4'd7);
        flush = 1'b1; iss_ready = 1'b1;
        at_neg();
        chk("flush_pre_count", count, 3);
        chk("flush_iss_valid", iss_valid, 0);
        chk("flush_in_ready", in_ready, 0);
        step(); flush = 1'b0; in_valid = 1'b0; iss_ready = 1'b0;
        at_neg();
        chk("flush_count", count, 0);
        chk("flush_after_iss_valid", iss_valid, 0);
        step(); iss_ready = 1'b1;
        disp(4'd6, 1, 4'd7, 1, 4'd13);
        exp_q.push_back({4'd6, 4'd7, 4'd13});
        step(); in_valid = 1'b0;
        at_neg();
        chk("post_flush_rw", iss_rw_tag, 13);
        step();
        at_neg();
        chk("post_flush_count", count, 0);

        // Reset mid-operation discards entries
        step(); iss_ready = 1'b0;
        disp(4'd1, 1, 4'd2, 1, 4'd3);
        step(); step(); in_valid = 1'b0; rst = 1'b1;
        step(); rst = 1'b0;
        at_neg();
        chk("mid_rst_count", count, 0);
        chk("mid_rst_iss_valid", iss_valid, 0);

        step(); step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
